// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU/MDU: op encodings, FSM states and op-class decode.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD    = 5'b00000;
    localparam logic [OP_W-1:0] ALU_SUB    = 5'b01000;
    localparam logic [OP_W-1:0] ALU_SLL    = 5'b00001;
    localparam logic [OP_W-1:0] ALU_SLT    = 5'b00010;
    localparam logic [OP_W-1:0] ALU_SLTU   = 5'b00011;
    localparam logic [OP_W-1:0] ALU_XOR    = 5'b00100;
    localparam logic [OP_W-1:0] ALU_SRL    = 5'b00101;
    localparam logic [OP_W-1:0] ALU_SRA    = 5'b01101;
    localparam logic [OP_W-1:0] ALU_OR     = 5'b00110;
    localparam logic [OP_W-1:0] ALU_AND    = 5'b00111;
    localparam logic [OP_W-1:0] ALU_MUL    = 5'b10000;
    localparam logic [OP_W-1:0] ALU_MULH   = 5'b10001;
    localparam logic [OP_W-1:0] ALU_MULHSU = 5'b10010;
    localparam logic [OP_W-1:0] ALU_MULHU  = 5'b10011;
    localparam logic [OP_W-1:0] ALU_DIV    = 5'b10100;
    localparam logic [OP_W-1:0] ALU_DIVU   = 5'b10101;
    localparam logic [OP_W-1:0] ALU_REM    = 5'b10110;
    localparam logic [OP_W-1:0] ALU_REMU   = 5'b10111;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_e;
    typedef enum logic [1:0] {CLS_BASE, CLS_MUL, CLS_DIV, CLS_UNKNOWN} op_class_e;

    // Bit 3 is don't-care for M ops; unlisted base codes are unknown.
    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e cls;
        cls = CLS_UNKNOWN;
        if (op[4]) begin
            cls = op[2] ? CLS_DIV : CLS_MUL;
        end else begin
            case (op[3:0])
                4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: cls = CLS_BASE;
                default: cls = CLS_UNKNOWN;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative 1-bit/cycle multiply (shift-add) and restoring divide on operand magnitudes,
// with sign correction and half/quotient/remainder select presented combinationally.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_start,
    input  logic            i_calc,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last_c,
    output logic [XLEN-1:0] o_result_c
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_m;
    logic [2:0]       r_op;
    logic             r_neg_q;
    logic             r_neg_r;

    logic              w_signed_a, w_signed_b, w_sa, w_sb;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic [XLEN:0]     w_sum, w_shift, w_diff;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem;

    assign w_signed_a = i_op[2] ? ~i_op[0] : (i_op[1:0] != 2'b11);
    assign w_signed_b = i_op[2] ? ~i_op[0] : ~i_op[1];
    assign w_sa       = w_signed_a & i_a[XLEN-1];
    assign w_sb       = w_signed_b & i_b[XLEN-1];
    assign w_mag_a    = w_sa ? -i_a : i_a;
    assign w_mag_b    = w_sb ? -i_b : i_b;

    // Mul: {r_hi,r_lo} is the product shifting right; div: r_hi remainder, r_lo dividend->quotient.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_m};

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_lo : r_lo;
    assign w_rem    = r_neg_r ? -r_hi : r_hi;

    assign o_last_c = (r_cnt == '0);

    always_comb begin
        o_result_c = '0;
        if (r_op[2]) begin
            o_result_c = r_op[1] ? w_rem : w_quo;
        end else begin
            o_result_c = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start) begin
            r_cnt   <= CNT_W'(XLEN - 1);
            r_hi    <= '0;
            r_op    <= i_op;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            if (i_op[2]) begin
                r_lo <= w_mag_a;
                r_m  <= w_mag_b;
            end else begin
                r_lo <= w_mag_b;
                r_m  <= w_mag_a;
            end
        end else if (i_calc) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_op[2]) begin
                if (!w_diff[XLEN]) begin
                    r_hi <= w_diff[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage ALU with registered result and valid/ready handshake; M ops run on the
// iterative datapath, everything else (and divide special cases) completes in one cycle.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter bit          M_EXT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] opers1_i,
    input  logic [XLEN-1:0] opers2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            zero_o
);

    localparam int unsigned   SHAMT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          r_state;
    op_class_e       w_cls;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0] w_base, w_special, w_quick, w_iter_res;
    logic            w_div0, w_ovf, w_iter, w_accept, w_start, w_last;

    assign w_cls   = op_class(op_i);
    assign w_shamt = opers2_i[SHAMT_W-1:0];
    assign w_div0  = (opers2_i == '0);
    assign w_ovf   = ~op_i[0] & (opers1_i == INT_MIN) & (opers2_i == '1);
    assign w_special = w_div0 ? (op_i[1] ? opers1_i : '1) : (op_i[1] ? '0 : opers1_i);
    assign w_iter  = M_EXT & ((w_cls == CLS_MUL) | ((w_cls == CLS_DIV) & ~w_div0 & ~w_ovf));

    assign in_ready_o = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready_i);
    assign w_accept   = in_valid_i & in_ready_o & ~flush_i;
    assign w_start    = w_accept & w_iter;

    always_comb begin
        w_base = '0;
        case (op_i[3:0])
            4'b0000: w_base = opers1_i + opers2_i;
            4'b1000: w_base = opers1_i - opers2_i;
            4'b0001: w_base = opers1_i << w_shamt;
            4'b0010: w_base = {{(XLEN-1){1'b0}}, $signed(opers1_i) < $signed(opers2_i)};
            4'b0011: w_base = {{(XLEN-1){1'b0}}, opers1_i < opers2_i};
            4'b0100: w_base = opers1_i ^ opers2_i;
            4'b0101: w_base = opers1_i >> w_shamt;
            4'b1101: w_base = XLEN'($signed(opers1_i) >>> w_shamt);
            4'b0110: w_base = opers1_i | opers2_i;
            4'b0111: w_base = opers1_i & opers2_i;
            default: w_base = '0;
        endcase
    end

    // Single-cycle result: base ops, divide special cases; unknown and disabled M ops give 0.
    always_comb begin
        w_quick = '0;
        case (w_cls)
            CLS_BASE: w_quick = w_base;
            CLS_DIV:  w_quick = M_EXT ? w_special : '0;
            default:  w_quick = '0;
        endcase
    end

    generate
        if (M_EXT) begin : g_mdu
            alu_mdu_iter #(.XLEN(XLEN)) u_iter (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .i_start    (w_start),
                .i_calc     (r_state == ST_CALC),
                .i_op       (op_i[2:0]),
                .i_a        (opers1_i),
                .i_b        (opers2_i),
                .o_last_c   (w_last),
                .o_result_c (w_iter_res)
            );
        end else begin : g_no_mdu
            assign w_last     = 1'b0;
            assign w_iter_res = '0;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            res_o       <= '0;
            zero_o      <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (flush_i) begin
            r_state     <= ST_IDLE;
            out_valid_o <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            r_state     <= ST_CALC;
                            out_valid_o <= 1'b0;
                        end else begin
                            r_state     <= ST_DONE;
                            res_o       <= w_quick;
                            zero_o      <= (w_quick == '0);
                            out_valid_o <= 1'b1;
                        end
                    end else if ((r_state == ST_DONE) && out_ready_i) begin
                        r_state     <= ST_IDLE;
                        out_valid_o <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (w_last) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_state     <= ST_DONE;
                    res_o       <= w_iter_res;
                    zero_o      <= (w_iter_res == '0);
                    out_valid_o <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: directed corner cases plus randomized ops against a
// plain-arithmetic reference model; a negedge monitor checks results, latency and hold stability.
module tb_alu_mdu_seq;

    localparam int unsigned XLEN = 64;
    localparam int          LAT_M = XLEN + 2;
    localparam logic [63:0] MINV  = 64'h8000_0000_0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, zero_o;
    logic [4:0]  op_i;
    logic [63:0] opers1_i, opers2_i, res_o;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
        logic [4:0]  op;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;
    bit   hold     = 1'b0;
    bit   stall    = 1'b0;
    bit   rnd_rdy  = 1'b0;
    logic [63:0] prev_res;
    logic [3:0]  base_codes [10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};

    alu_mdu_seq #(.XLEN(XLEN), .M_EXT(1'b1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .opers1_i    (opers1_i),
        .opers2_i    (opers2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .res_o       (res_o),
        .zero_o      (zero_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb2;
        int                 sh;
        bit                 ovf;
        sa  = a;
        sb2 = b;
        sh  = int'(b[5:0]);
        ovf = (a == MINV) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        if (!op[4]) begin
            case (op[3:0])
                4'h0: return a + b;
                4'h8: return a - b;
                4'h1: return a << sh;
                4'h2: return (sa < sb2) ? 64'd1 : 64'd0;
                4'h3: return (a < b) ? 64'd1 : 64'd0;
                4'h4: return a ^ b;
                4'h5: return a >> sh;
                4'hD: return sa >>> sh;
                4'h6: return a | b;
                4'h7: return a & b;
                default: return 64'd0;
            endcase
        end
        case (op[2:0])
            3'd0: return a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
            3'd4: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : 64'(sa / sb2));
            3'd5: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb2));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        if (!op[4]) return 1;
        if (op[2] && (b == 0 || (!op[0] && a == MINV && b == 64'hFFFF_FFFF_FFFF_FFFF))) return 1;
        return LAT_M;
    endfunction

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return MINV;
            3: return 64'($urandom_range(0, 20));
            4: return {$urandom, $urandom};
            default: return -64'($urandom_range(1, 20));
        endcase
    endfunction

    // Consumer: out_ready changes just after the edge so the monitor sees it stable.
    always @(posedge clk_i) begin
        #2;
        out_ready_i = stall ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Monitor: latency on first valid of each item, hold stability, result compare on handshake.
    always @(negedge clk_i) begin
        if (rst_i) begin
            seen = 1'b0;
            hold = 1'b0;
        end else begin
            if (out_valid_o && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) check("unexpected_out_valid", 64'(out_valid_o), 64'd0);
                else check($sformatf("latency op=%h", sb[0].op), 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
            end
            if (hold && out_valid_o) check("held_res_stable", res_o, prev_res);
            hold     = out_valid_o && !out_ready_i;
            prev_res = res_o;
            if (out_valid_o && out_ready_i && sb.size() > 0) begin
                check($sformatf("res op=%h", sb[0].op), res_o, sb[0].res);
                check($sformatf("zero op=%h", sb[0].op), 64'(zero_o), 64'(sb[0].res == 64'd0));
                void'(sb.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input bit push, output int waits);
        exp_t e;
        waits = 0;
        @(negedge clk_i);
        in_valid_i = 1'b1;
        op_i       = op;
        opers1_i   = a;
        opers2_i   = b;
        while (!in_ready_o && waits < 500) begin
            @(negedge clk_i);
            waits++;
        end
        if (!in_ready_o) begin
            check("accept_timeout", 64'(in_ready_o), 64'd1);
            in_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        op_i       = 5'($urandom);
        opers1_i   = {$urandom, $urandom};
        opers2_i   = {$urandom, $urandom};
        if (push) begin
            e.res = model(op, a, b);
            e.lat = model_lat(op, a, b);
            e.acc = cyc;
            e.op  = op;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int w;
        logic [4:0] op;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b1;
        op_i        = 5'b00000;
        opers1_i    = 64'd1;
        opers2_i    = 64'd1;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_out_valid", 64'(out_valid_o), 64'd0);
        check("reset_res", res_o, 64'd0);
        check("reset_zero", 64'(zero_o), 64'd0);
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_out_valid", 64'(out_valid_o), 64'd0);

        issue(5'b00000, 64'd5, 64'd7, 1'b1, w);
        issue(5'b01000, 64'd3, 64'd3, 1'b1, w);
        issue(5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, w);
        issue(5'b00011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, w);
        issue(5'b01101, MINV, 64'd4, 1'b1, w);
        issue(5'b00001, 64'd1, 64'd65, 1'b1, w);
        issue(5'b10000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, w);
        issue(5'b10001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, w);
        issue(5'b10011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, w);
        issue(5'b10100, -64'd7, 64'd2, 1'b1, w);
        issue(5'b10110, -64'd7, 64'd2, 1'b1, w);
        issue(5'b10101, 64'd7, 64'd0, 1'b1, w);
        issue(5'b10111, 64'd7, 64'd0, 1'b1, w);
        issue(5'b10100, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
        issue(5'b10110, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
        drain();

        // Consumer stalls 10 cycles in DONE, then back-to-back ADDs.
        stall = 1'b1;
        issue(5'b00000, 64'd100, 64'd200, 1'b1, w);
        @(negedge clk_i);
        repeat (10) begin
            @(negedge clk_i);
            check("stall_in_ready", 64'(in_ready_o), 64'd0);
            check("stall_out_valid", 64'(out_valid_o), 64'd1);
        end
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(5'b00000, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, w);
            if (i > 0) check("b2b_no_bubble", 64'(w), 64'd0);
        end
        drain();

        // Flush in the middle of CALC.
        issue(5'b10001, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, w);
        repeat (30) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_out_valid", 64'(out_valid_o), 64'd0);
        check("flush_in_ready", 64'(in_ready_o), 64'd1);
        issue(5'b00000, 64'd40, 64'd2, 1'b1, w);
        drain();

        // Flush beats a simultaneous accept.
        @(negedge clk_i);
        in_valid_i = 1'b1;
        op_i       = 5'b00000;
        opers1_i   = 64'd9;
        opers2_i   = 64'd9;
        flush_i    = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_beats_accept", 64'(out_valid_o), 64'd0);

        // Reset in the middle of CALC: no partial result.
        issue(5'b10100, 64'd1000, 64'd7, 1'b0, w);
        repeat (20) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rst_calc_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_calc_res", res_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        w = 0;
        repeat (70) begin
            @(negedge clk_i);
            if (out_valid_o) w++;
        end
        check("rst_calc_no_result", 64'(w), 64'd0);

        // Randomized traffic with a randomly stalling consumer.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 3))
                0, 1: op = {1'b0, base_codes[$urandom_range(0, 9)]};
                2:    op = {1'b1, 4'($urandom)};
                default: op = {1'b0, 4'($urandom)};
            endcase
            issue(op, rnd_opnd(), rnd_opnd(), 1'b1, w);
        end
        drain();
        rnd_rdy = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
